audio_delay_effect: RTL and testbench

- Parametrised stereo echo/delay successor to the codec-side feedback effect.
- Sits between the audio codec serialiser and its sample strobes (sample_end / sample_req).
- Captures each channel's input on sample_end and runs it through a per-channel circular delay line of DEPTH samples.
- Presents a saturated dry/echo mix on sample_req; the mode is selectable at run time through the 4-bit control word.

---
 rtl/audio_fx_pkg.sv | 41 ++++
 rtl/audio_delay_line.sv | 112 +++++++++++
 rtl/audio_delay_effect.sv | 57 +++++
 tb/tb_audio_delay_effect.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_fx_pkg.sv
// Shared definitions for the stereo delay effect: mode encoding, control word
// layout and the saturating adder used by each delay line.
package audio_fx_pkg;

  typedef enum logic [1:0] {
    FX_MUTE     = 2'b00,
    FX_PASS     = 2'b01,
    FX_ECHO     = 2'b10,
    FX_FEEDBACK = 2'b11
  } fx_mode_e;

  localparam int CTRL_MODE_LSB  = 0;
  localparam int CTRL_MODE_MSB  = 1;
  localparam int CTRL_SHIFT_LSB = 2;
  localparam int CTRL_SHIFT_MSB = 3;

  // Widest sample the saturating adder handles; callers sign-extend into it.
  localparam int SAT_MAX_W = 32;

  // Adds two sign-extended operands and clamps to a width-bit signed range.
  function automatic logic signed [SAT_MAX_W-1:0] sat_add(
    input logic signed [SAT_MAX_W-1:0] a,
    input logic signed [SAT_MAX_W-1:0] b,
    input int unsigned                 width
  );
    logic signed [SAT_MAX_W:0] sum;
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    sum = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
    hi  = (33'sd1 <<< (width - 32'd1)) - 33'sd1;
    lo  = -(33'sd1 <<< (width - 32'd1));
    if (sum > hi) begin
      sat_add = hi[SAT_MAX_W-1:0];
    end else if (sum < lo) begin
      sat_add = lo[SAT_MAX_W-1:0];
    end else begin
      sat_add = sum[SAT_MAX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/audio_delay_line.sv
// One channel of the delay effect: circular sample ring, priming flag and the
// capture / mix / commit pipeline feeding a held result register.
module audio_delay_line
  import audio_fx_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sample_end,
  input  logic [WIDTH-1:0] audio_in,
  input  logic [3:0]       control,
  output logic [WIDTH-1:0] held_out
);

  logic signed [WIDTH-1:0] ram [DEPTH];
  logic signed [WIDTH-1:0] rd_data;
  logic [ADDR_W-1:0]       wr_ptr;
  logic                    primed;
  logic                    cap_valid;
  logic                    mix_valid;
  logic signed [WIDTH-1:0] in_r;
  logic [3:0]              ctrl_r;
  logic signed [WIDTH-1:0] res_r;
  logic signed [WIDTH-1:0] wdata_r;
  logic [WIDTH-1:0]        held;

  logic                    accept;
  fx_mode_e                mode;
  logic [2:0]              shift;
  logic signed [WIDTH-1:0] delayed;
  logic signed [WIDTH-1:0] echo;
  logic signed [WIDTH-1:0] mix;
  logic signed [WIDTH-1:0] result;
  logic signed [WIDTH-1:0] store;

  // Strobes landing while a sample is still in flight are dropped.
  assign accept   = sample_end & ~(cap_valid | mix_valid);
  assign held_out = held;

  // Ring storage has no reset so it maps onto synchronous-read block RAM.
  always_ff @(posedge clk) begin
    if (mix_valid) begin
      ram[wr_ptr] <= wdata_r;
    end
    if (accept) begin
      rd_data <= ram[wr_ptr];
    end
  end

  // Mix stage: shift the delayed sample, add, saturate, select by mode.
  always_comb begin
    mode    = fx_mode_e'(ctrl_r[CTRL_MODE_MSB:CTRL_MODE_LSB]);
    shift   = {1'b0, ctrl_r[CTRL_SHIFT_MSB:CTRL_SHIFT_LSB]} + 3'd1;
    delayed = primed ? rd_data : '0;
    echo    = delayed >>> shift;
    mix     = WIDTH'(sat_add(SAT_MAX_W'(in_r), SAT_MAX_W'(echo), WIDTH));
    case (mode)
      FX_MUTE:     result = '0;
      FX_PASS:     result = in_r;
      FX_ECHO:     result = mix;
      FX_FEEDBACK: result = mix;
      default:     result = '0;
    endcase
    if (mode == FX_FEEDBACK) begin
      store = result;
    end else begin
      store = in_r;
    end
  end

  // Capture and mix registers; reset drops any sample still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_valid <= 1'b0;
      mix_valid <= 1'b0;
      in_r      <= '0;
      ctrl_r    <= 4'd0;
      res_r     <= '0;
      wdata_r   <= '0;
    end else begin
      cap_valid <= accept;
      mix_valid <= cap_valid;
      if (accept) begin
        in_r   <= audio_in;
        ctrl_r <= control;
      end
      if (cap_valid) begin
        res_r   <= result;
        wdata_r <= store;
      end
    end
  end

  // Commit stage: publish result, advance the ring, mark primed after one lap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held   <= '0;
      wr_ptr <= '0;
      primed <= 1'b0;
    end else if (mix_valid) begin
      held   <= res_r;
      wr_ptr <= wr_ptr + ADDR_W'(1);
      if (wr_ptr == ADDR_W'(DEPTH - 1)) begin
        primed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_delay_effect.sv
// Stereo echo/delay effect between the codec serialiser strobes: two
// independent delay lines plus the registered codec-facing outputs.
module audio_delay_effect
  import audio_fx_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       sample_end,
  input  logic [1:0]       sample_req,
  input  logic [WIDTH-1:0] audio_input_l,
  input  logic [WIDTH-1:0] audio_input_r,
  input  logic [3:0]       control,
  output logic [WIDTH-1:0] audio_output_l,
  output logic [WIDTH-1:0] audio_output_r
);

  logic [WIDTH-1:0] held_l;
  logic [WIDTH-1:0] held_r;

  audio_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_left (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_end (sample_end[1]),
    .audio_in   (audio_input_l),
    .control    (control),
    .held_out   (held_l)
  );

  audio_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_right (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_end (sample_end[0]),
    .audio_in   (audio_input_r),
    .control    (control),
    .held_out   (held_r)
  );

  // Codec outputs only change when that channel is requested.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      audio_output_l <= '0;
      audio_output_r <= '0;
    end else begin
      if (sample_req[1]) begin
        audio_output_l <= held_l;
      end
      if (sample_req[0]) begin
        audio_output_r <= held_r;
      end
    end
  end

endmodule

// File: tb/tb_audio_delay_effect.sv
// Scoreboard bench for audio_delay_effect (DEPTH=4): directed vectors plus a
// randomized stream checked against a queue-based delay model.
module tb_audio_delay_effect;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        sample_end = 2'b00;
  logic [1:0]        sample_req = 2'b00;
  logic [WIDTH-1:0]  audio_input_l = '0;
  logic [WIDTH-1:0]  audio_input_r = '0;
  logic [3:0]        control = 4'd0;
  logic [WIDTH-1:0]  audio_output_l;
  logic [WIDTH-1:0]  audio_output_r;

  audio_delay_effect #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sample_end     (sample_end),
    .sample_req     (sample_req),
    .audio_input_l  (audio_input_l),
    .audio_input_r  (audio_input_r),
    .control        (control),
    .audio_output_l (audio_output_l),
    .audio_output_r (audio_output_r)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Reference model: per channel, the last DEPTH stored samples (oldest first).
  int line_l[$];
  int line_r[$];
  int held_old[2];
  int held_new[2];
  int ready_edge[2];
  int out_exp[2];

  typedef struct { int l; int r; } exp_t;
  exp_t exp_q[$];

  function automatic int to_s(logic [15:0] x);
    return int'($signed(x));
  endfunction

  function automatic int sat(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int model_step(int ch, int x, logic [3:0] ctrl);
    int d, res, store, s;
    d = 0;
    s = int'(ctrl[3:2]) + 1;
    if (ch == 1) begin
      if (line_l.size() == DEPTH) d = line_l[0];
    end else begin
      if (line_r.size() == DEPTH) d = line_r[0];
    end
    case (ctrl[1:0])
      2'b00:   res = 0;
      2'b01:   res = x;
      default: res = sat(x + (d >>> s));
    endcase
    store = (ctrl[1:0] == 2'b11) ? res : x;
    if (ch == 1) begin
      line_l.push_back(store);
      if (line_l.size() > DEPTH) void'(line_l.pop_front());
    end else begin
      line_r.push_back(store);
      if (line_r.size() > DEPTH) void'(line_r.pop_front());
    end
    return res;
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; expectations are derived here from the model.
  task automatic drive(logic [1:0] em, logic [1:0] rm, logic [15:0] l,
                       logic [15:0] r, logic [3:0] ctrl);
    int e;
    @(negedge clk);
    e = cyc + 1;
    sample_end = em;
    sample_req = rm;
    audio_input_l = l;
    audio_input_r = r;
    control = ctrl;
    if (rm != 2'b00) begin
      for (int ch = 0; ch < 2; ch++)
        if (rm[ch]) out_exp[ch] = (e > ready_edge[ch]) ? held_new[ch] : held_old[ch];
      exp_q.push_back('{out_exp[1], out_exp[0]});
    end
    for (int ch = 0; ch < 2; ch++) begin
      if (em[ch] && e > ready_edge[ch]) begin
        held_old[ch] = held_new[ch];
        held_new[ch] = model_step(ch, to_s(ch == 1 ? l : r), ctrl);
        ready_edge[ch] = e + 2;
      end
    end
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 16'h0000, 16'h0000, 4'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    sample_end = 2'b00;
    sample_req = 2'b00;
    #1;
    check("reset_out_l", audio_output_l, 16'h0000);
    check("reset_out_r", audio_output_r, 16'h0000);
    line_l.delete();
    line_r.delete();
    for (int ch = 0; ch < 2; ch++) begin
      held_old[ch] = 0;
      held_new[ch] = 0;
      ready_edge[ch] = -10;
      out_exp[ch] = 0;
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Full sample: strobe in, request 3 cycles later, optionally check literals.
  task automatic process(logic [1:0] m, logic [15:0] l, logic [15:0] r,
                         logic [3:0] ctrl, bit chk, logic [15:0] el,
                         logic [15:0] er, string name);
    drive(m, 2'b00, l, r, ctrl);
    idle();
    idle();
    drive(2'b00, m, 16'h0000, 16'h0000, 4'd0);
    idle();
    if (chk) begin
      if (m[1]) check({name, "_l"}, audio_output_l, el);
      if (m[0]) check({name, "_r"}, audio_output_r, er);
    end
  endtask

  // Monitor: every request is compared against the next scoreboard entry.
  always @(posedge clk) begin : monitor
    exp_t it;
    if (reset_n && sample_req != 2'b00) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_underflow: got output with no expectation queued");
      end else begin
        it = exp_q.pop_front();
        check("sb_left", audio_output_l, 16'(it.l));
        check("sb_right", audio_output_r, 16'(it.r));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] echo_exp [6];
    logic [15:0] v;
    echo_exp = '{16'h1000, 16'h0000, 16'h0000, 16'h0000, 16'h0800, 16'h0000};

    do_reset();

    // Pass-through latency on the left channel.
    drive(2'b10, 2'b00, 16'h0100, 16'h0000, 4'b0001);
    drive(2'b00, 2'b10, 16'h0000, 16'h0000, 4'd0);
    idle();
    check("lat_early_l", audio_output_l, 16'h0000);
    drive(2'b00, 2'b10, 16'h0000, 16'h0000, 4'd0);
    idle();
    check("lat_3cyc_l", audio_output_l, 16'h0100);

    // Reset mid-stream aborts the in-flight sample; then mute.
    process(2'b11, 16'h5555, 16'h6666, 4'b0001, 1'b1, 16'h5555, 16'h6666, "pass");
    drive(2'b11, 2'b00, 16'h7777, 16'h7777, 4'b0001);
    do_reset();
    for (int i = 0; i < 5; i++)
      process(2'b11, 16'h1234, 16'h1234, 4'b0000, 1'b1, 16'h0000, 16'h0000, "mute");

    // Echo with priming.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      v = (i == 0) ? 16'h1000 : 16'h0000;
      process(2'b11, v, v, 4'b0010, 1'b1, echo_exp[i], echo_exp[i], "echo");
    end

    // Feedback decay of an impulse.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      v = (i == 0) ? 16'h4000 : 16'h0000;
      process(2'b11, v, v, 4'b0011, 1'b1,
              (i % 4 == 0) ? (16'h4000 >> (i / 4)) : 16'h0000,
              (i % 4 == 0) ? (16'h4000 >> (i / 4)) : 16'h0000, "fb");
    end

    // Saturation: left positive, right negative.
    do_reset();
    for (int i = 0; i < 4; i++)
      process(2'b11, 16'h7000, 16'h9000, 4'b0010, 1'b1, 16'h7000, 16'h9000, "prefill");
    process(2'b11, 16'h7000, 16'h9000, 4'b0010, 1'b1, 16'h7FFF, 16'h8000, "sat");

    // Simultaneous channels.
    process(2'b11, 16'h0011, 16'h0022, 4'b0001, 1'b1, 16'h0011, 16'h0022, "simul");

    // Strobe inside the busy window is dropped.
    drive(2'b10, 2'b00, 16'h0AAA, 16'h0000, 4'b0001);
    drive(2'b10, 2'b00, 16'h0BBB, 16'h0000, 4'b0001);
    idle();
    drive(2'b00, 2'b10, 16'h0000, 16'h0000, 4'd0);
    idle();
    check("drop_busy_l", audio_output_l, 16'h0AAA);

    // Randomized stream, checked by the monitor.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            16'($urandom), 16'($urandom), 4'($urandom));
      repeat ($urandom_range(0, 3))
        drive(2'b00, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 4'($urandom));
    end
    repeat (4) idle();
    check("sb_drained", 16'(exp_q.size()), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
